mult_div_unit: RTL and testbench

//   Iterative HI/LO multiply/divide unit for the MIPS datapath. It consumes the two

---
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit.sv | 135 +++++++++++++
 tb/tb_mult_div_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the MIPS datapath and the HI/LO
// multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] wrData;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srcA, srcB, hiWrite, loWrite, wrData,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, hiWrite, loWrite, wrData,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per clock on operand magnitudes, sign fix-up at the end.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_op_div;
  logic             r_sgn_q;
  logic             r_sgn_r;
  logic             r_bz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;

  logic             w_open;
  logic             w_accept;
  logic             w_signed;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_dshift;
  logic             w_dge;
  logic [WIDTH-1:0] w_ddiff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = w_open && bus.start;
  assign w_signed = ~bus.op[0];
  assign w_neg_a  = w_signed & bus.srcA[WIDTH-1];
  assign w_neg_b  = w_signed & bus.srcB[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -bus.srcA : bus.srcA;
  assign w_abs_b  = w_neg_b ? -bus.srcB : bus.srcB;

  // Multiply: r_rem:r_q is the running product, r_q shifts the multiplier out.
  assign w_msum   = {1'b0, r_rem} + {1'b0, (r_q[0] ? r_a : '0)};
  // Divide: r_q shifts the dividend out and the quotient in.
  assign w_dshift = {r_rem, r_q[WIDTH-1]};
  assign w_dge    = (w_dshift >= {1'b0, r_a});
  assign w_ddiff  = w_dshift[WIDTH-1:0] - r_a;

  assign w_prod     = {r_rem, r_q};
  assign w_prod_fix = r_sgn_q ? -w_prod : w_prod;
  assign w_quo      = r_bz ? '1 : (r_sgn_q ? -r_q : r_q);
  assign w_rem      = r_sgn_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CW'(WIDTH-1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = bus.start ? S_CALC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_op_div <= 1'b0;
      r_sgn_q  <= 1'b0;
      r_sgn_r  <= 1'b0;
      r_bz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_op_div <= bus.op[1];
        r_sgn_q  <= w_signed & (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
        r_sgn_r  <= w_neg_a;
        r_bz     <= (bus.srcB == '0);
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CW'(1);
      end

      // A start in the same cycle as MTHI/MTLO drops the write.
      if (r_state == S_FIX) begin
        if (r_op_div) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end else if (w_open && !bus.start) begin
        if (bus.hiWrite) r_hi <= bus.wrData;
        if (bus.loWrite) r_lo <= bus.wrData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a   <= bus.op[1] ? w_abs_b : w_abs_a;
      r_q   <= bus.op[1] ? w_abs_a : w_abs_b;
      r_rem <= '0;
    end else if (r_state == S_CALC) begin
      if (r_op_div) begin
        r_rem <= w_dge ? w_ddiff : w_dshift[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], w_dge};
      end else begin
        r_rem <= w_msum[WIDTH:1];
        r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
      end
    end
  end

  assign bus.busy = (r_state == S_CALC) || (r_state == S_FIX);
  assign bus.done = (r_state == S_DONE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized bench for mult_div_unit with a result scoreboard.
module tb_mult_div_unit;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  res_t sb[$];

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sp;
    longint unsigned up;
    int sa, sb2, q, m;
    case (op)
      2'b00: begin
        sa = a; sb2 = b;
        sp = longint'(sa) * longint'(sb2);
        r = {sp[63:32], sp[31:0]};
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        r = {up[63:32], up[31:0]};
      end
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          sa = a; sb2 = b;
          q = sa / sb2; m = sa % sb2;
          r = {m, q};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.srcA  = a;
    bus.srcB  = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits for done (bounded), checks latency, busy length and the scoreboard head.
  task automatic finish_op(input string tag, input int cyc0);
    int cyc;
    int busy_n;
    res_t exp;
    cyc = cyc0;
    busy_n = cyc0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) busy_n++;
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd33);
    chk({tag, "_busy"}, 64'(busy_n), 64'd33);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk({tag, "_res"}, {bus.hi, bus.lo}, exp);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input res_t exp);
    sb.push_back(exp);
    launch(op, a, b);
    finish_op(tag, 0);
  endtask

  initial begin
    int seen;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    n_total = 0;
    n_pass  = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.srcA = '0; bus.srcB = '0;
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0; bus.wrData = '0;
    tick(); tick();
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    reset = 1'b1;
    tick();

    run("mult_neg", 2'b00, 32'd7, 32'hFFFF_FFFD, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    tick();
    chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
    run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    tick();
    run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();
    run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    tick();
    run("divu_zero", 2'b11, 32'd100, 32'd0, {32'h0000_0064, 32'hFFFF_FFFF});
    tick();
    run("div_zero_neg", 2'b10, 32'hFFFF_FF9C, 32'd0, {32'hFFFF_FF9C, 32'hFFFF_FFFF});
    tick();

    // A second start while busy must not disturb the running operation.
    sb.push_back({32'd0, 32'd42});
    launch(2'b01, 32'd6, 32'd7);
    repeat (4) tick();
    bus.start = 1'b1; bus.op = 2'b11; bus.srcA = 32'd1000; bus.srcB = 32'd3;
    tick();
    bus.start = 1'b0;
    finish_op("start_ignored", 5);
    tick();

    bus.loWrite = 1'b1; bus.wrData = 32'h1234;
    tick();
    bus.loWrite = 1'b0;
    chk("mtlo_idle", {32'd0, bus.lo}, {32'd0, 32'h1234});
    bus.hiWrite = 1'b1; bus.loWrite = 1'b1; bus.wrData = 32'h5A5A_A5A5;
    tick();
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    chk("mthi_mtlo_both", {bus.hi, bus.lo}, {32'h5A5A_A5A5, 32'h5A5A_A5A5});

    sb.push_back({32'd2, 32'd14});
    launch(2'b10, 32'd100, 32'd7);
    repeat (2) tick();
    bus.loWrite = 1'b1; bus.wrData = 32'h1234;
    tick();
    bus.loWrite = 1'b0;
    chk("mtlo_busy_ignored", {bus.hi, bus.lo}, {32'h5A5A_A5A5, 32'h5A5A_A5A5});
    repeat (17) tick();
    chk("hilo_hold_calc", {bus.hi, bus.lo}, {32'h5A5A_A5A5, 32'h5A5A_A5A5});
    finish_op("div_with_mtlo", 20);
    tick();

    sb.push_back({32'd0, 32'd15});
    bus.loWrite = 1'b1; bus.wrData = 32'hDEAD;
    launch(2'b01, 32'd3, 32'd5);
    bus.loWrite = 1'b0;
    chk("start_beats_mtlo", {32'd0, bus.lo}, {32'd0, 32'd14});
    finish_op("start_mtlo_res", 0);
    tick();

    run("b2b_first", 2'b11, 32'hFFFF_FFFF, 32'd16, {32'd15, 32'h0FFF_FFFF});
    run("b2b_second", 2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'd0});
    tick();
    chk("b2b_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom());
      run($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
      tick();
    end

    // Reset during an operation aborts it without a done pulse.
    launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) tick();
    bus.start = 1'b1; bus.op = 2'b10; bus.srcA = 32'd9; bus.srcB = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    tick();
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      if (bus.done) seen++;
      tick();
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
